stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
- Run/pause/clear/lap sequencer for the stopwatch time counter.
- Consumes the debounced start, clear and lap button levels and the live 46-bit count.
- Drives the counter enable and clear, and stores up to LAP_DEPTH split times.
- Selects the 46-bit value handed to the digit-extraction/display path: live, frozen split, or recalled lap.

Parameters:
- CNT_W, 46, width of count value (10 ns ticks).
- LAP_DEPTH, 8, number of lap registers.
- IDX_W, 3, width of lap index (clog2 LAP_DEPTH).

Ports:
- clkIn  in  1  100 MHz system clock.
- rstW  in  1  reset; asynchronous, active-high.
- startIn  in  1  debounced start/pause level.
- clearIn  in  1  debounced clear level.
- lapIn  in  1  debounced lap/recall level.
- cntValIn  in  CNT_W  live value from the time counter.
- cntEnOut  out  1  enable to the time counter.
- cntClrOut  out  1  one-cycle synchronous clear to the time counter.
- dispValOut  out  CNT_W  value to be shown on the display.
- lapIdxOut  out  IDX_W  lap currently displayed (SPLIT/RECALL).
- lapCountOut  out  IDX_W+1  number of stored laps, 0..LAP_DEPTH.
- lapFullOut  out  1  lapCountOut == LAP_DEPTH.
- runningOut  out  1  counter currently enabled.

Behaviour:
- Reset: all outputs 0 and state IDLE.
  - Edge-detect registers, lapCount and lapIdx are cleared.
  - Lap storage contents are don't-care (unreachable while lapCount = 0).
  - Reset mid-operation aborts at once with no pending clear pulse.
- Edge detection:
  - Each button has a registered previous level, reset 0.
  - Event = level 1 and previous 0; exactly one event per press.
  - The event is acted on at the same clock edge where it is detected.
- Priority when events coincide: clear > start > lap. An event with no meaning in the current state is dropped, and the next-priority event is considered.
- States and transitions:
  - IDLE:
    - start -> RUN.
    - clear and lap are ignored.
  - RUN (cntEnOut=1):
    - start -> PAUSE.
    - lap, not full -> write cntValIn to lap[lapCount], lapIdx<=lapCount, lapCount+1, go to SPLIT.
    - lap while full -> ignored, stay in RUN.
    - clear -> ignored.
  - SPLIT (cntEnOut=1, display frozen):
    - lap, not full -> store as in RUN, stay in SPLIT with the display moved to the new lap.
    - clear -> RUN (releases the freeze only; counter untouched).
    - start -> PAUSE.
  - PAUSE (cntEnOut=0):
    - start -> RUN.
    - clear -> IDLE, with cntClrOut=1 for exactly one cycle and lapCount<=0.
    - lap with lapCount>0 -> RECALL, lapIdx<=0.
    - lap with lapCount=0 -> ignored.
  - RECALL (cntEnOut=0):
    - lap -> lapIdx+1, wrapping to 0 after lapCount-1.
    - start -> PAUSE.
    - clear -> IDLE, with the same clear behaviour as in PAUSE.
- cntEnOut and runningOut decode directly from the state register. They change at the edge where the transition is taken; there is no extra latency.
- dispValOut is registered, with one cycle of latency from its source:
  - IDLE/RUN/PAUSE: cntValIn.
  - SPLIT/RECALL: lap[lapIdx].
- Lap write captures cntValIn sampled at the event edge. It takes effect on the next edge. The SPLIT display shows the captured value starting 2 edges after the event.
- Counter wrap-around (99:59:59.99 -> 0) is invisible to this block; stored laps are not modified.
- Widths:
  - lapCount saturates at LAP_DEPTH.
  - lapIdx never reaches ≥ lapCount while in SPLIT/RECALL.

Decomposition:
- stopwatch_pkg holds:
  - the state encoding (IDLE, RUN, PAUSE, SPLIT, RECALL, 3 bits);
  - the CNT_W default;
  - MAX_CNT and the per-digit divisor constants, shared with the top level.
- One sub-module, lap_file: LAP_DEPTH x CNT_W register file.
  - One synchronous write port (wrEn, wrIdx, wrData).
  - One asynchronous read port (rdIdx).
  - No reset on storage.

Test Plan:
- Reset, then start pulse -> at the event edge: cntEnOut=1, runningOut=1. dispValOut tracks cntValIn with 1 cycle lag.
- RUN, lap at cntValIn=46'd1000, then cntValIn continues -> state SPLIT, lapCountOut=1, lapIdxOut=0, dispValOut holds 1000 while cntEnOut stays 1. A clear event returns to the live value.
- 9 lap events in RUN/SPLIT with cntValIn=100,200..900 -> lapCountOut=8, lapFullOut=1, ninth ignored, dispValOut=800.
- Pause with 3 laps (10,20,30), then 4 lap events -> RECALL shows 10,20,30,10. lapIdxOut sequence is 0,1,2,0. cntEnOut=0 throughout.
- PAUSE, clear and start events in the same cycle -> clear wins: IDLE, cntClrOut high exactly 1 cycle, lapCountOut=0, cntEnOut=0.
- RUN with 2 laps, rstW asserted asynchronously mid-cycle -> all outputs 0 immediately with no cntClrOut pulse. After release, a lap event in IDLE has no effect.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch control slice: sequencer state
// encoding, count width and the tick constants used by the display path.
package stopwatch_pkg;

    localparam int CNT_W_DEF = 46;

    // Last representable time 99:59:59.99 expressed in 10 ns ticks.
    localparam logic [45:0] MAX_CNT        = 46'd35999999999999;

    // Ticks per displayed digit unit (10 ns base tick).
    localparam logic [45:0] TICKS_PER_CSEC = 46'd1000000;
    localparam logic [45:0] TICKS_PER_SEC  = 46'd100000000;
    localparam logic [45:0] TICKS_PER_MIN  = 46'd6000000000;
    localparam logic [45:0] TICKS_PER_HOUR = 46'd360000000000;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_SPLIT  = 3'd3,
        ST_RECALL = 3'd4
    } swState_t;

endpackage

// File: rtl/lap_file.sv
// Lap register file: one synchronous write port, one asynchronous read port.
// Storage has no reset; entries beyond the stored lap count are never read.
module lap_file #(
    parameter int CNT_W     = 46,
    parameter int LAP_DEPTH = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clkIn,
    input  logic             wrEn,
    input  logic [IDX_W-1:0] wrIdx,
    input  logic [CNT_W-1:0] wrData,
    input  logic [IDX_W-1:0] rdIdx,
    output logic [CNT_W-1:0] rdData
);

    logic [CNT_W-1:0] memR [LAP_DEPTH];

    // Capture a split time into the addressed lap entry.
    always_ff @(posedge clkIn) begin
        if (wrEn) begin
            memR[wrIdx] <= wrData;
        end
    end

    assign rdData = memR[rdIdx];

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/clear/lap sequencer for the stopwatch time counter. Button
// levels are edge-detected and the resulting events are acted on at the
// same edge; coinciding events resolve as clear > start > lap, with an
// event that means nothing in the current state falling through to the
// next one.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int LAP_DEPTH = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clkIn,
    input  logic             rstW,
    input  logic             startIn,
    input  logic             clearIn,
    input  logic             lapIn,
    input  logic [CNT_W-1:0] cntValIn,
    output logic             cntEnOut,
    output logic             cntClrOut,
    output logic [CNT_W-1:0] dispValOut,
    output logic [IDX_W-1:0] lapIdxOut,
    output logic [IDX_W:0]   lapCountOut,
    output logic             lapFullOut,
    output logic             runningOut
);

    localparam logic [IDX_W:0] LAP_CNT_MAX = (IDX_W+1)'(LAP_DEPTH);

    swState_t         stateR;
    swState_t         stateNxtS;
    logic             startPrevR;
    logic             clearPrevR;
    logic             lapPrevR;
    logic             startEvS;
    logic             clearEvS;
    logic             lapEvS;
    logic [IDX_W:0]   lapCountR;
    logic [IDX_W:0]   lapCountNxtS;
    logic [IDX_W-1:0] lapIdxR;
    logic [IDX_W-1:0] lapIdxNxtS;
    logic             lapFullR;
    logic             cntClrR;
    logic             cntClrNxtS;
    logic             wrEnS;
    logic [CNT_W-1:0] rdDataS;
    logic [CNT_W-1:0] dispValR;
    logic             frozenS;
    logic             canStoreS;
    logic             lastIdxS;

    assign startEvS  = startIn & ~startPrevR;
    assign clearEvS  = clearIn & ~clearPrevR;
    assign lapEvS    = lapIn   & ~lapPrevR;
    assign canStoreS = (lapCountR != LAP_CNT_MAX);
    assign lastIdxS  = (({1'b0, lapIdxR} + {{IDX_W{1'b0}}, 1'b1}) >= lapCountR);
    assign frozenS   = (stateR == ST_SPLIT) || (stateR == ST_RECALL);

    lap_file #(
        .CNT_W     (CNT_W),
        .LAP_DEPTH (LAP_DEPTH),
        .IDX_W     (IDX_W)
    ) uLapFile (
        .clkIn  (clkIn),
        .wrEn   (wrEnS),
        .wrIdx  (lapCountR[IDX_W-1:0]),
        .wrData (cntValIn),
        .rdIdx  (lapIdxR),
        .rdData (rdDataS)
    );

    // Next-state, lap bookkeeping and clear-pulse decision for each state.
    always_comb begin
        stateNxtS    = stateR;
        lapCountNxtS = lapCountR;
        lapIdxNxtS   = lapIdxR;
        cntClrNxtS   = 1'b0;
        wrEnS        = 1'b0;
        case (stateR)
            ST_IDLE: begin
                if (startEvS) begin
                    stateNxtS = ST_RUN;
                end else begin
                    stateNxtS = ST_IDLE;
                end
            end
            ST_RUN, ST_SPLIT: begin
                if (clearEvS && (stateR == ST_SPLIT)) begin
                    stateNxtS = ST_RUN;
                end else if (startEvS) begin
                    stateNxtS = ST_PAUSE;
                end else if (lapEvS && canStoreS) begin
                    wrEnS        = 1'b1;
                    lapIdxNxtS   = lapCountR[IDX_W-1:0];
                    lapCountNxtS = lapCountR + {{IDX_W{1'b0}}, 1'b1};
                    stateNxtS    = ST_SPLIT;
                end else begin
                    stateNxtS = stateR;
                end
            end
            ST_PAUSE, ST_RECALL: begin
                if (clearEvS) begin
                    stateNxtS    = ST_IDLE;
                    cntClrNxtS   = 1'b1;
                    lapCountNxtS = {(IDX_W+1){1'b0}};
                    lapIdxNxtS   = {IDX_W{1'b0}};
                end else if (startEvS) begin
                    stateNxtS = (stateR == ST_PAUSE) ? ST_RUN : ST_PAUSE;
                end else if (lapEvS && (stateR == ST_RECALL)) begin
                    lapIdxNxtS = lastIdxS ? {IDX_W{1'b0}}
                                          : lapIdxR + {{(IDX_W-1){1'b0}}, 1'b1};
                end else if (lapEvS && (lapCountR != {(IDX_W+1){1'b0}})) begin
                    stateNxtS  = ST_RECALL;
                    lapIdxNxtS = {IDX_W{1'b0}};
                end else begin
                    stateNxtS = stateR;
                end
            end
            default: begin
                stateNxtS = ST_IDLE;
            end
        endcase
    end

    // State, edge-detect history, lap counters and the clear pulse.
    always_ff @(posedge clkIn or posedge rstW) begin
        if (rstW) begin
            stateR     <= ST_IDLE;
            startPrevR <= 1'b0;
            clearPrevR <= 1'b0;
            lapPrevR   <= 1'b0;
            lapCountR  <= {(IDX_W+1){1'b0}};
            lapIdxR    <= {IDX_W{1'b0}};
            lapFullR   <= 1'b0;
            cntClrR    <= 1'b0;
        end else begin
            stateR     <= stateNxtS;
            startPrevR <= startIn;
            clearPrevR <= clearIn;
            lapPrevR   <= lapIn;
            lapCountR  <= lapCountNxtS;
            lapIdxR    <= lapIdxNxtS;
            lapFullR   <= (lapCountNxtS == LAP_CNT_MAX);
            cntClrR    <= cntClrNxtS;
        end
    end

    // Display register: live count, or the selected lap while frozen.
    always_ff @(posedge clkIn or posedge rstW) begin
        if (rstW) begin
            dispValR <= {CNT_W{1'b0}};
        end else if (frozenS) begin
            dispValR <= rdDataS;
        end else begin
            dispValR <= cntValIn;
        end
    end

    assign cntEnOut    = (stateR == ST_RUN) || (stateR == ST_SPLIT);
    assign runningOut  = cntEnOut;
    assign cntClrOut   = cntClrR;
    assign dispValOut  = dispValR;
    assign lapIdxOut   = lapIdxR;
    assign lapCountOut = lapCountR;
    assign lapFullOut  = lapFullR;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: directed scenarios plus random button traffic,
// all checked every cycle against a behavioural model of the stopwatch.
module tb_stopwatch_ctrl;

    logic        clkIn;
    logic        rstW;
    logic        startIn;
    logic        clearIn;
    logic        lapIn;
    logic [45:0] cntValIn;
    logic        cntEnOut;
    logic        cntClrOut;
    logic [45:0] dispValOut;
    logic [2:0]  lapIdxOut;
    logic [3:0]  lapCountOut;
    logic        lapFullOut;
    logic        runningOut;

    int errCnt = 0;
    int chkCnt = 0;

    // Model: counting / display-frozen / idle flags, stored laps, shown lap.
    bit          mRun;
    bit          mFrozen;
    bit          mIdle;
    bit          mClr;
    int          mIdx;
    logic [45:0] mDisp;
    logic [45:0] laps[$];
    bit          mPrevSt;
    bit          mPrevCl;
    bit          mPrevLp;

    stopwatch_ctrl dut (
        .clkIn       (clkIn),
        .rstW        (rstW),
        .startIn     (startIn),
        .clearIn     (clearIn),
        .lapIn       (lapIn),
        .cntValIn    (cntValIn),
        .cntEnOut    (cntEnOut),
        .cntClrOut   (cntClrOut),
        .dispValOut  (dispValOut),
        .lapIdxOut   (lapIdxOut),
        .lapCountOut (lapCountOut),
        .lapFullOut  (lapFullOut),
        .runningOut  (runningOut)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chkCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        mRun = 0; mFrozen = 0; mIdle = 1; mClr = 0; mIdx = 0;
        mDisp = '0; laps.delete();
        mPrevSt = 0; mPrevCl = 0; mPrevLp = 0;
    endtask

    // One clock edge of stopwatch behaviour, from the current button levels.
    task automatic modelEdge();
        bit stEv, clEv, lpEv;
        stEv = startIn && !mPrevSt;
        clEv = clearIn && !mPrevCl;
        lpEv = lapIn   && !mPrevLp;
        mPrevSt = startIn; mPrevCl = clearIn; mPrevLp = lapIn;
        mDisp = mFrozen ? laps[mIdx] : cntValIn;
        mClr  = 0;
        if (mIdle) begin
            if (stEv) begin mIdle = 0; mRun = 1; end
        end else if (mRun) begin
            if (clEv && mFrozen) mFrozen = 0;
            else if (stEv) begin mRun = 0; mFrozen = 0; end
            else if (lpEv && laps.size() < 8) begin
                laps.push_back(cntValIn);
                mIdx = laps.size() - 1;
                mFrozen = 1;
            end
        end else begin
            if (clEv) begin
                mIdle = 1; mFrozen = 0; mIdx = 0; mClr = 1;
                laps.delete();
            end else if (stEv) begin
                if (mFrozen) mFrozen = 0;
                else mRun = 1;
            end else if (lpEv && laps.size() > 0) begin
                if (mFrozen) mIdx = (mIdx + 1) % laps.size();
                else begin mFrozen = 1; mIdx = 0; end
            end
        end
    endtask

    task automatic compareAll();
        checkVal("cntEn",    cntEnOut,    mRun);
        checkVal("running",  runningOut,  mRun);
        checkVal("cntClr",   cntClrOut,   mClr);
        checkVal("dispVal",  dispValOut,  mDisp);
        checkVal("lapIdx",   lapIdxOut,   mIdx);
        checkVal("lapCount", lapCountOut, laps.size());
        checkVal("lapFull",  lapFullOut,  laps.size() == 8);
    endtask

    // Drive levels at the falling edge, model the rising edge, check at the next fall.
    task automatic step(input logic st, input logic cl, input logic lp, input logic [45:0] cnt);
        startIn = st; clearIn = cl; lapIn = lp; cntValIn = cnt;
        @(posedge clkIn);
        modelEdge();
        @(negedge clkIn);
        compareAll();
    endtask

    task automatic press(input logic st, input logic cl, input logic lp, input logic [45:0] cnt);
        step(st, cl, lp, cnt);
        step(1'b0, 1'b0, 1'b0, cnt);
    endtask

    initial begin
        logic [63:0] r;
        rstW = 1'b1; startIn = 0; clearIn = 0; lapIn = 0; cntValIn = '0;
        modelReset();
        repeat (2) @(negedge clkIn);
        compareAll();
        rstW = 1'b0;

        // Start, live tracking.
        press(1, 0, 0, 46'd5);
        checkVal("start_run", runningOut, 1'b1);
        step(0, 0, 0, 46'd6);
        step(0, 0, 0, 46'd7);

        // Lap at 1000 freezes the display while the count keeps moving.
        press(0, 0, 1, 46'd1000);
        step(0, 0, 0, 46'd1002);
        step(0, 0, 0, 46'd1003);
        checkVal("split_hold", dispValOut, 46'd1000);
        checkVal("split_en", cntEnOut, 1'b1);
        press(0, 1, 0, 46'd1004);
        step(0, 0, 0, 46'd1006);
        checkVal("split_release", dispValOut, 46'd1005 + 46'd1);

        // Pause, clear, restart, then nine laps: the ninth is dropped.
        press(1, 0, 0, 46'd1);
        press(0, 1, 0, 46'd1);
        press(1, 0, 0, 46'd2);
        for (int k = 1; k <= 9; k++) press(0, 0, 1, 46'(k * 100));
        step(0, 0, 0, 46'd950);
        checkVal("full_count", lapCountOut, 4'd8);
        checkVal("full_flag", lapFullOut, 1'b1);
        checkVal("full_disp", dispValOut, 46'd800);

        // Three laps, pause, recall cycles through them with wrap.
        press(1, 0, 0, 46'd3);
        press(0, 1, 0, 46'd3);
        press(1, 0, 0, 46'd4);
        press(0, 0, 1, 46'd10);
        press(0, 0, 1, 46'd20);
        press(0, 0, 1, 46'd30);
        press(1, 0, 0, 46'd40);
        for (int k = 0; k < 4; k++) begin
            logic [45:0] want;
            want = (k == 3) ? 46'd10 : 46'(10 * (k + 1));
            press(0, 0, 1, 46'd41);
            checkVal("recall_disp", dispValOut, want);
            checkVal("recall_en", cntEnOut, 1'b0);
        end

        // Coinciding clear and start in PAUSE: clear wins.
        press(1, 0, 0, 46'd50);
        step(1, 1, 0, 46'd51);
        checkVal("clr_pulse", cntClrOut, 1'b1);
        checkVal("clr_laps", lapCountOut, 4'd0);
        step(0, 0, 0, 46'd52);
        checkVal("clr_single", cntClrOut, 1'b0);
        checkVal("clr_idle", cntEnOut, 1'b0);

        // Asynchronous reset in RUN with two laps.
        press(1, 0, 0, 46'd60);
        press(0, 0, 1, 46'd61);
        press(0, 1, 0, 46'd62);
        press(0, 0, 1, 46'd63);
        #2 rstW = 1'b1;
        #1;
        checkVal("rst_en", cntEnOut, 1'b0);
        checkVal("rst_clr", cntClrOut, 1'b0);
        checkVal("rst_disp", dispValOut, 46'd0);
        checkVal("rst_laps", lapCountOut, 4'd0);
        checkVal("rst_idx", lapIdxOut, 3'd0);
        @(negedge clkIn);
        rstW = 1'b0;
        modelReset();
        press(0, 0, 1, 46'd70);
        checkVal("idle_lap", lapCountOut, 4'd0);

        // Random button traffic and count values.
        for (int n = 0; n < 3000; n++) begin
            r = {$urandom(), $urandom()};
            step($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 1) == 0, r[45:0]);
        end

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule
